// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: seconds-tick prescaler plus RUN/SET_HR/SET_MIN set-time FSM; buttons in, tick_en/load strobe/edit values/mode/blink out
module clock_mode_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       tick_en,
  output logic       load_en,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic [1:0] mode,
  output logic [4:0] edit_hours,
  output logic [5:0] edit_minutes,
  output logic       blink
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} state_t;
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BLINK_DIV - 1);
  state_t state;
  logic [PW-1:0] presc;
  logic [BW-1:0] bcnt;
  assign tick_en = state == RUN && presc == P_MAX && !btn_mode;
  assign mode = state;
  assign load_hours = edit_hours;
  assign load_minutes = edit_minutes;
  assign load_seconds = '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      presc <= '0;
      bcnt <= '0;
      blink <= 1'b0;
      load_en <= 1'b0;
      edit_hours <= '0;
      edit_minutes <= '0;
    end else begin
      load_en <= 1'b0;
      if (state != RUN) begin
        bcnt <= bcnt == B_MAX ? '0 : bcnt + 1'b1;
        blink <= bcnt == B_MAX ? ~blink : blink;
      end
      case (state)
        RUN: begin
          presc <= (btn_mode || load_en || presc == P_MAX) ? '0 : presc + 1'b1;
          if (btn_mode) begin
            state <= SET_HR;
            edit_hours <= cur_hours;
            edit_minutes <= cur_minutes;
            blink <= 1'b1;
            bcnt <= '0;
          end
        end
        SET_HR: begin
          if (btn_mode) state <= SET_MIN;
          else if (btn_inc) edit_hours <= edit_hours == 5'd23 ? '0 : edit_hours + 5'd1;
        end
        SET_MIN: begin
          if (btn_mode) begin
            state <= RUN;
            load_en <= 1'b1;
            blink <= 1'b0;
            bcnt <= '0;
          end else if (btn_inc) edit_minutes <= edit_minutes == 6'd59 ? '0 : edit_minutes + 6'd1;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
